// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int REQ_ADDR_W = 9;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [2:0]            funct3;
  } req_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for one access: store byte enables and merge,
// load lane select with sign/zero extension, and access legality.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_ram_word,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_data,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wdata_rep;
  logic [3:0]  w_mask;
  logic        w_illegal;
  logic        w_misaligned;

  assign w_byte = i_ram_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_ram_word[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    w_mask       = 4'b0000;
    w_wdata_rep  = i_wdata;
    o_load_data  = 32'h0;
    case (i_funct3)
      F3_B, F3_BU: begin
        w_mask      = 4'b0001 << i_lane;
        w_wdata_rep = {4{i_wdata[7:0]}};
        o_load_data = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      F3_H, F3_HU: begin
        w_misaligned = i_lane[0];
        w_mask       = 4'b0011 << {i_lane[1], 1'b0};
        w_wdata_rep  = {2{i_wdata[15:0]}};
        o_load_data  = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      F3_W: begin
        w_misaligned = |i_lane;
        w_mask       = 4'b1111;
        o_load_data  = i_ram_word;
      end
      default: w_illegal = 1'b1;
    endcase
    // unsigned variants exist only for loads
    if (i_we && i_funct3[2]) w_illegal = 1'b1;

    o_err = w_illegal | w_misaligned;
    o_be  = (o_err || !i_we) ? 4'b0000 : w_mask;
    if (o_err || i_we) o_load_data = 32'h0;

    o_store_word = i_ram_word;
    for (int b = 0; b < 4; b++) begin
      if (o_be[b]) o_store_word[8*b +: 8] = w_wdata_rep[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states,
// serving byte/half/word loads and stores from an internal little-endian RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = REQ_ADDR_W,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  // state | meaning
  // IDLE  | ready for a request; accept latches it
  // WAIT  | counting down wait states
  // RESP  | one-cycle response pulse; access already done on entry

  localparam int         DEPTH    = 1 << (DM_ADDRESS - 2);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  generate
    if (DATA_W != 32 || DM_ADDRESS != REQ_ADDR_W || WAIT_CYCLES < 0 || WAIT_CYCLES > 15)
    begin : g_bad_param
      $error("dmem_responder: unsupported parameter set");
    end
  endgenerate

  state_t              r_state;
  logic [3:0]          r_cnt;
  req_t                r_req;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH];

  req_t                w_live;
  req_t                w_cur;
  logic                w_accept;
  logic                w_enter_resp;
  logic [DM_ADDRESS-3:0] w_idx;
  logic [31:0]         w_ram_word;
  logic [31:0]         w_store_word;
  logic [31:0]         w_load;
  logic [3:0]          w_be;
  logic                w_err;

  assign req_ready = reset && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_live    = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
  // zero wait states access memory on the accept edge, before r_req is loaded
  assign w_cur      = (r_state == IDLE) ? w_live : r_req;
  assign w_idx      = w_cur.addr[DM_ADDRESS-1:2];
  assign w_ram_word = r_mem[w_idx];

  assign w_enter_resp = ((r_state == IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0));

  dmem_lane_fmt u_lane_fmt (
    .i_we         (w_cur.we),
    .i_funct3     (w_cur.funct3),
    .i_lane       (w_cur.addr[1:0]),
    .i_ram_word   (w_ram_word),
    .i_wdata      (w_cur.wdata),
    .o_be         (w_be),
    .o_store_word (w_store_word),
    .o_load_data  (w_load),
    .o_err        (w_err)
  );

  // merged word already preserves the untouched lanes
  always_ff @(posedge clk) begin
    if (w_enter_resp && (|w_be)) r_mem[w_idx] <= w_store_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rdata     <= w_load;
        r_err       <= w_err;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req <= w_live;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (0 and 2 wait states) against a byte-array reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        t_valid [2];
  logic        t_ready [2];
  logic        t_we    [2];
  logic [8:0]  t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [2:0]  t_f3    [2];
  logic        t_rv    [2];
  logic [31:0] t_rdata [2];
  logic        t_err   [2];
  logic        t_busy  [2];

  logic [7:0] m_mem [2][512];
  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(t_valid[0]), .req_ready(t_ready[0]),
    .req_we(t_we[0]), .req_addr(t_addr[0]), .req_wdata(t_wdata[0]), .req_funct3(t_f3[0]),
    .rsp_valid(t_rv[0]), .rsp_rdata(t_rdata[0]), .rsp_err(t_err[0]), .busy(t_busy[0])
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(t_valid[1]), .req_ready(t_ready[1]),
    .req_we(t_we[1]), .req_addr(t_addr[1]), .req_wdata(t_wdata[1]), .req_funct3(t_f3[1]),
    .rsp_valid(t_rv[1]), .rsp_rdata(t_rdata[1]), .rsp_err(t_err[1]), .busy(t_busy[1])
  );

  function automatic int wc(input int s);
    return (s == 1) ? 2 : 0;
  endfunction

  // Reference: size from funct3[1:0], legality table, alignment by modulo, plain byte array.
  function automatic void model(input int s, input logic we, input logic [8:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [31:0] rd, output logic err);
    int size;
    bit legal;
    longint v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((int'(a) % size) != 0);
    rd    = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) m_mem[s][int'(a) + i] = 8'(wd >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(m_mem[s][int'(a) + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v - (longint'(1) << (8 * size));
      rd = 32'(v);
    end
  endfunction

  task automatic do_op(input int s, input logic we, input logic [8:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic err,
                       output int lat);
    rd  = 32'h0;
    err = 1'b0;
    lat = -1;
    @(negedge clk);
    t_we[s] = we; t_addr[s] = a; t_wdata[s] = wd; t_f3[s] = f3; t_valid[s] = 1'b1;
    for (int k = 0; k < 20 && t_ready[s] !== 1'b1; k++) @(negedge clk);
    @(posedge clk);
    #1;
    // scramble inputs: only the accept-edge values may matter
    t_valid[s] = 1'b0; t_we[s] = ~we; t_addr[s] = ~a; t_wdata[s] = $urandom; t_f3[s] = ~f3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (t_rv[s] === 1'b1) begin
        rd = t_rdata[s]; err = t_err[s]; lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      n_tests++;
      if (t_ready[s] !== 1'b0 || t_rv[s] !== 1'b0 || t_rdata[s] !== 32'h0 ||
          t_err[s] !== 1'b0 || t_busy[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_values s=%0d: got rdy=%b rv=%b rd=%h err=%b busy=%b expected all 0",
                 s, t_ready[s], t_rv[s], t_rdata[s], t_err[s], t_busy[s]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      n_tests++;
      if (t_ready[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_after_reset s=%0d: got %b expected 1", s, t_ready[s]);
      end
    end
  endtask

  task automatic init_mem;
    logic [31:0] wd, rd, erd;
    logic err, eerr;
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 128; w++) begin
        wd = $urandom;
        model(s, 1'b1, 9'(w * 4), wd, F3_W, erd, eerr);
        do_op(s, 1'b1, 9'(w * 4), wd, F3_W, rd, err, lat);
        n_tests++;
        if (err !== 1'b0 || rd !== 32'h0 || lat !== wc(s) + 1) begin
          n_fail++;
          $display("FAIL init_sw s=%0d w=%0d: got err=%b rd=%h lat=%0d expected 0 0 %0d",
                   s, w, err, rd, lat, wc(s) + 1);
        end
      end
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] rd;
    logic        err;
  } op_t;

  task automatic test_directed;
    op_t ops[$];
    op_t op;
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat;
    ops.push_back('{1'b1, 9'h010, 32'hDEADBEEF, F3_W,  32'h00000000, 1'b0});
    ops.push_back('{1'b0, 9'h010, 32'h0,        F3_W,  32'hDEADBEEF, 1'b0});
    ops.push_back('{1'b1, 9'h010, 32'h00000000, F3_W,  32'h00000000, 1'b0});
    ops.push_back('{1'b1, 9'h013, 32'hABCDEF80, F3_B,  32'h00000000, 1'b0});
    ops.push_back('{1'b0, 9'h013, 32'h0,        F3_B,  32'hFFFFFF80, 1'b0});
    ops.push_back('{1'b0, 9'h013, 32'h0,        F3_BU, 32'h00000080, 1'b0});
    ops.push_back('{1'b0, 9'h010, 32'h0,        F3_W,  32'h80000000, 1'b0});
    ops.push_back('{1'b1, 9'h020, 32'h11112222, F3_W,  32'h00000000, 1'b0});
    ops.push_back('{1'b1, 9'h022, 32'h55558001, F3_H,  32'h00000000, 1'b0});
    ops.push_back('{1'b0, 9'h022, 32'h0,        F3_H,  32'hFFFF8001, 1'b0});
    ops.push_back('{1'b0, 9'h022, 32'h0,        F3_HU, 32'h00008001, 1'b0});
    ops.push_back('{1'b0, 9'h021, 32'h0,        F3_H,  32'h00000000, 1'b1});
    ops.push_back('{1'b0, 9'h020, 32'h0,        F3_W,  32'h80012222, 1'b0});
    ops.push_back('{1'b0, 9'h010, 32'h0,        3'b011, 32'h00000000, 1'b1});
    ops.push_back('{1'b1, 9'h010, 32'hFFFFFFFF, F3_BU, 32'h00000000, 1'b1});
    ops.push_back('{1'b1, 9'h012, 32'hFFFFFFFF, F3_W,  32'h00000000, 1'b1});
    ops.push_back('{1'b0, 9'h010, 32'h0,        F3_W,  32'h80000000, 1'b0});
    for (int i = 0; i < ops.size(); i++) begin
      op = ops[i];
      model(1, op.we, op.a, op.wd, op.f3, mrd, merr);
      do_op(1, op.we, op.a, op.wd, op.f3, rd, err, lat);
      n_tests++;
      if (rd !== op.rd || err !== op.err || lat !== 3) begin
        n_fail++;
        $display("FAIL directed #%0d: got rd=%h err=%b lat=%0d expected rd=%h err=%b lat=3",
                 i, rd, err, lat, op.rd, op.err);
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int rsp = 0;
    logic [8:0]  a, last_a;
    logic [31:0] wd, rd, erd;
    logic err, eerr;
    int lat;
    last_a = 9'h0;
    @(negedge clk);
    t_valid[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (t_ready[0] !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL b2b_ready i=%0d: got %b expected %0d", i, t_ready[0], (i % 2) == 0);
      end
      if (t_rv[0] === 1'b1) rsp++;
      if (i == 11) begin
        t_valid[0] = 1'b0;
      end else begin
        a  = 9'($urandom_range(0, 127) * 4);
        wd = $urandom;
        t_we[0] = 1'b1; t_addr[0] = a; t_wdata[0] = wd; t_f3[0] = F3_W;
        if (t_ready[0] === 1'b1) begin
          model(0, 1'b1, a, wd, F3_W, erd, eerr);
          acc++;
          last_a = a;
        end
      end
    end
    @(negedge clk);
    if (t_rv[0] === 1'b1) rsp++;
    n_tests++;
    if (acc != 6 || rsp != acc) begin
      n_fail++;
      $display("FAIL b2b_counts: got accepts=%0d responses=%0d expected 6 and 6", acc, rsp);
    end
    model(0, 1'b0, last_a, 32'h0, F3_W, erd, eerr);
    do_op(0, 1'b0, last_a, 32'h0, F3_W, rd, err, lat);
    n_tests++;
    if (rd !== erd || err !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_readback: got rd=%h err=%b lat=%0d expected rd=%h err=0 lat=1",
               rd, err, lat, erd);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] old, rd;
    logic e, err;
    int lat;
    bit saw_rsp = 0;
    model(1, 1'b0, 9'h040, 32'h0, F3_W, old, e);
    @(negedge clk);
    t_we[1] = 1'b1; t_addr[1] = 9'h040; t_wdata[1] = 32'h12345678; t_f3[1] = F3_W;
    t_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    t_valid[1] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (t_busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy_before: got %b expected 1", t_busy[1]);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (t_busy[1] !== 1'b0 || t_ready[1] !== 1'b0 || t_rv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got busy=%b rdy=%b rv=%b expected 0 0 0",
               t_busy[1], t_ready[1], t_rv[1]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (t_rv[1] !== 1'b0 || t_ready[1] !== 1'b0) saw_rsp = 1;
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (t_rv[1] !== 1'b0) saw_rsp = 1;
    end
    n_tests++;
    if (saw_rsp) begin
      n_fail++;
      $display("FAIL mid_no_rsp: got rsp_valid or req_ready during/after reset, expected none");
    end
    do_op(1, 1'b0, 9'h040, 32'h0, F3_W, rd, err, lat);
    n_tests++;
    if (rd !== old || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_store_discarded: got rd=%h err=%b expected rd=%h err=0", rd, err, old);
    end
  endtask

  task automatic test_random(input int s, input int n);
    logic we, err, eerr;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] wd, rd, erd;
    int size, lat;
    for (int k = 0; k < n; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 > 3'd2) f3 = f3 + 3'd1;
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      size = 1 << f3[1:0];
      a = 9'($urandom_range(0, 511));
      if (size <= 4 && $urandom_range(0, 9) < 8) a = a & ~9'(size - 1);
      wd = $urandom;
      model(s, we, a, wd, f3, erd, eerr);
      do_op(s, we, a, wd, f3, rd, err, lat);
      n_tests++;
      if (rd !== erd || err !== eerr) begin
        n_fail++;
        $display("FAIL rand_data s=%0d we=%b f3=%0d a=%h: got rd=%h err=%b expected rd=%h err=%b",
                 s, we, f3, a, rd, err, erd, eerr);
      end
      n_tests++;
      if (lat !== wc(s) + 1) begin
        n_fail++;
        $display("FAIL rand_latency s=%0d: got %0d expected %0d", s, lat, wc(s) + 1);
      end
      @(negedge clk);
      n_tests++;
      if (t_rv[s] !== 1'b0 || t_ready[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_pulse_end s=%0d: got rv=%b rdy=%b expected 0 1", s, t_rv[s], t_ready[s]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      t_valid[s] = 1'b0; t_we[s] = 1'b0; t_addr[s] = 9'h0; t_wdata[s] = 32'h0; t_f3[s] = 3'b0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    init_mem();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random(1, 150);
    test_random(0, 150);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
